// File: rtl/ext_domain_power_seq_pkg.sv
// Shared types and default timing parameters for the external power-domain sequencer.
package ext_domain_power_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    SW_ON,
    CLK_ON,
    RST_REL,
    ON,
    ISO_ON,
    RST_ON,
    SW_OFF
  } pwr_seq_state_e;

  localparam int unsigned DEF_ISO_CYCLES  = 4;
  localparam int unsigned DEF_RST_CYCLES  = 8;
  localparam int unsigned DEF_ACK_TIMEOUT = 64;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ext_domain_power_seq_ack_sync.sv
// Multi-flop synchronizer for the asynchronous switch-cell acknowledge.
module ack_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/ext_domain_power_seq.sv
// Power-gating sequencer: orders switch, clock, reset and isolation for one external domain.
module ext_domain_power_seq
  import ext_domain_power_seq_pkg::*;
#(
  parameter int unsigned ISO_CYCLES  = DEF_ISO_CYCLES,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_req_i,
  input  logic switch_ack_ni,
  input  logic timeout_clr_i,
  output logic switch_no,
  output logic iso_o,
  output logic domain_rst_no,
  output logic clk_en_o,
  output logic on_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned SEQ_MAX = max2(ISO_CYCLES, RST_CYCLES);
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned TO_W    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SEQ_W-1:0] RST_LAST = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] ISO_LAST = SEQ_W'(ISO_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  pwr_seq_state_e   state_reg, state_next;
  logic [SEQ_W-1:0] seq_cnt_reg, seq_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             timeout_reg, timeout_next;
  logic             ack_s;
  logic             ack_wait;

  ack_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_ack_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (switch_ack_ni),
    .q     (ack_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= OFF;
      seq_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      seq_cnt_reg <= seq_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // The dwell counter only advances while the state holds, so any transition clears it.
  always_comb begin
    state_next   = state_reg;
    seq_cnt_next = '0;
    case (state_reg)
      OFF: begin
        if (pwr_req_i) state_next = SW_ON;
      end
      SW_ON: begin
        if (!ack_s) state_next = CLK_ON;
      end
      CLK_ON: begin
        if (seq_cnt_reg == RST_LAST) state_next = RST_REL;
        else                         seq_cnt_next = seq_cnt_reg + 1'b1;
      end
      RST_REL: begin
        if (seq_cnt_reg == ISO_LAST) state_next = ON;
        else                         seq_cnt_next = seq_cnt_reg + 1'b1;
      end
      ON: begin
        if (!pwr_req_i) state_next = ISO_ON;
      end
      ISO_ON: begin
        if (seq_cnt_reg == ISO_LAST) state_next = RST_ON;
        else                         seq_cnt_next = seq_cnt_reg + 1'b1;
      end
      RST_ON: begin
        state_next = SW_OFF;
      end
      SW_OFF: begin
        if (ack_s) state_next = OFF;
      end
      default: begin
        state_next = OFF;
      end
    endcase
  end

  // Ack wait counter saturates; the flag sets only on the edge the limit is reached.
  always_comb begin
    ack_wait     = ((state_reg == SW_ON)  && (state_next == SW_ON)) ||
                   ((state_reg == SW_OFF) && (state_next == SW_OFF));
    to_cnt_next  = '0;
    timeout_next = timeout_reg;
    if (ack_wait) begin
      to_cnt_next = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + 1'b1;
    end
    if (timeout_clr_i) timeout_next = 1'b0;
    if (ack_wait && (to_cnt_reg == TO_LAST)) timeout_next = 1'b1;
  end

  always_comb begin
    switch_no     = 1'b1;
    iso_o         = 1'b1;
    domain_rst_no = 1'b0;
    clk_en_o      = 1'b0;
    on_o          = 1'b0;
    busy_o        = 1'b1;
    case (state_reg)
      OFF: begin
        busy_o = 1'b0;
      end
      SW_ON: begin
        switch_no = 1'b0;
      end
      CLK_ON: begin
        switch_no = 1'b0;
        clk_en_o  = 1'b1;
      end
      RST_REL: begin
        switch_no     = 1'b0;
        clk_en_o      = 1'b1;
        domain_rst_no = 1'b1;
      end
      ON: begin
        switch_no     = 1'b0;
        clk_en_o      = 1'b1;
        domain_rst_no = 1'b1;
        iso_o         = 1'b0;
        on_o          = 1'b1;
        busy_o        = 1'b0;
      end
      ISO_ON: begin
        switch_no     = 1'b0;
        clk_en_o      = 1'b1;
        domain_rst_no = 1'b1;
      end
      RST_ON: begin
        switch_no = 1'b0;
      end
      SW_OFF: begin
        switch_no = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign timeout_o = timeout_reg;

endmodule
